turn_controller: RTL and testbench

Sequences one Connect Four move at a time. It takes the current player's column choice, tracks the fill height of every column and writes the dropped piece into the board store. It then hands the board to the win checker and waits for the verdict before passing the turn, or ending the game on a win or a draw. The block sits between the debounced button inputs and the board/win-check datapath, and replaces ad-hoc enter/change sequencing with one owner of turn state.

---
 rtl/turn_controller.sv | 165 ++++++++++++++++
 tb/tb_turn_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Connect Four turn sequencer: cursor movement, column fill tracking, board write
// and win-check handshake for one move at a time, plus win/draw end-of-game state.
module turn_controller #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       enter_i,
   input  logic       chk_done_i,
   input  logic       chk_win_i,
   output logic [2:0] cursor_o,
   output logic       player_o,
   output logic       wr_en_o,
   output logic [2:0] wr_col_o,
   output logic [2:0] wr_row_o,
   output logic       wr_player_o,
   output logic       chk_start_o,
   output logic       game_over_o,
   output logic       draw_o,
   output logic       winner_o
);

   localparam logic [2:0] LastCol    = 3'(COLS - 1);
   localparam logic [2:0] CursorInit = 3'(COLS / 2);
   localparam logic [2:0] FullHeight = 3'(ROWS);
   localparam logic [5:0] AllMoves   = 6'(COLS * ROWS);

   typedef enum logic [2:0] {
      SELECT,
      DROP,
      CHK_START,
      CHK_WAIT,
      OVER
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] cursor_q, cursor_d;
   logic       player_q, player_d;
   logic [5:0] moves_q, moves_d;
   logic [2:0] wrCol_q, wrCol_d;
   logic [2:0] wrRow_q, wrRow_d;
   logic       wrPlayer_q, wrPlayer_d;
   logic       draw_q, draw_d;
   logic       winner_q, winner_d;
   logic [2:0] height_q [COLS];
   logic       clearHeights;
   logic       bumpHeight;

   always_comb begin
      state_d      = state_q;
      cursor_d     = cursor_q;
      player_d     = player_q;
      moves_d      = moves_q;
      wrCol_d      = wrCol_q;
      wrRow_d      = wrRow_q;
      wrPlayer_d   = wrPlayer_q;
      draw_d       = draw_q;
      winner_d     = winner_q;
      clearHeights = 1'b0;
      bumpHeight   = 1'b0;

      case (state_q)
         SELECT: begin
            // enter freezes the cursor even when the column is full and the drop is refused
            if (enter_i) begin
               if (height_q[cursor_q] < FullHeight) begin
                  wrCol_d    = cursor_q;
                  wrRow_d    = height_q[cursor_q];
                  wrPlayer_d = player_q;
                  state_d    = DROP;
               end
            end else if (left_i && !right_i) begin
               cursor_d = (cursor_q == 3'd0) ? LastCol : cursor_q - 3'd1;
            end else if (right_i && !left_i) begin
               cursor_d = (cursor_q == LastCol) ? 3'd0 : cursor_q + 3'd1;
            end
         end
         DROP: begin
            bumpHeight = 1'b1;
            moves_d    = moves_q + 6'd1;
            state_d    = CHK_START;
         end
         CHK_START: begin
            state_d = CHK_WAIT;
         end
         CHK_WAIT: begin
            if (chk_done_i) begin
               if (chk_win_i) begin
                  winner_d = player_q;
                  state_d  = OVER;
               end else if (moves_q == AllMoves) begin
                  draw_d  = 1'b1;
                  state_d = OVER;
               end else begin
                  player_d = ~player_q;
                  state_d  = SELECT;
               end
            end
         end
         OVER: begin
            // winner deliberately survives the restart so it can still be shown
            if (enter_i) begin
               state_d      = SELECT;
               cursor_d     = CursorInit;
               player_d     = 1'b0;
               moves_d      = '0;
               draw_d       = 1'b0;
               clearHeights = 1'b1;
            end
         end
         default: begin
            state_d = SELECT;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q    <= SELECT;
         cursor_q   <= CursorInit;
         player_q   <= 1'b0;
         moves_q    <= '0;
         wrCol_q    <= '0;
         wrRow_q    <= '0;
         wrPlayer_q <= 1'b0;
         draw_q     <= 1'b0;
         winner_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cursor_q   <= cursor_d;
         player_q   <= player_d;
         moves_q    <= moves_d;
         wrCol_q    <= wrCol_d;
         wrRow_q    <= wrRow_d;
         wrPlayer_q <= wrPlayer_d;
         draw_q     <= draw_d;
         winner_q   <= winner_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i || clearHeights) begin
         for (int c = 0; c < COLS; c++) begin
            height_q[c] <= '0;
         end
      end else if (bumpHeight) begin
         height_q[wrCol_q] <= height_q[wrCol_q] + 3'd1;
      end
   end

   assign cursor_o    = cursor_q;
   assign player_o    = player_q;
   assign wr_en_o     = (state_q == DROP);
   assign wr_col_o    = wrCol_q;
   assign wr_row_o    = wrRow_q;
   assign wr_player_o = wrPlayer_q;
   assign chk_start_o = (state_q == CHK_START);
   assign game_over_o = (state_q == OVER);
   assign draw_o      = draw_q;
   assign winner_o    = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed scenarios with randomized column
// choices and verdict delays, compared against a move-level game model.
module tb_turn_controller;

   localparam int COLS = 7;
   localparam int ROWS = 6;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       left = 1'b0;
   logic       right = 1'b0;
   logic       enter = 1'b0;
   logic       chkDone = 1'b0;
   logic       chkWin = 1'b0;
   logic [2:0] cursor;
   logic       player;
   logic       wrEn;
   logic [2:0] wrCol;
   logic [2:0] wrRow;
   logic       wrPlayer;
   logic       chkStart;
   logic       gameOver;
   logic       draw;
   logic       winner;

   int assertCount = 0;
   int failCount = 0;

   // Game model: one entry per column, plus whose turn it is and how the game ended
   int mHeight [COLS];
   int mMoves;
   int mCursor;
   int mPlayer;
   int mWinner;
   int mOver;
   int mDraw;

   turn_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk_i       (clk),
      .reset_i     (resetN),
      .left_i      (left),
      .right_i     (right),
      .enter_i     (enter),
      .chk_done_i  (chkDone),
      .chk_win_i   (chkWin),
      .cursor_o    (cursor),
      .player_o    (player),
      .wr_en_o     (wrEn),
      .wr_col_o    (wrCol),
      .wr_row_o    (wrRow),
      .wr_player_o (wrPlayer),
      .chk_start_o (chkStart),
      .game_over_o (gameOver),
      .draw_o      (draw),
      .winner_o    (winner)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic l, input logic r, input logic e);
      left  = l;
      right = r;
      enter = e;
      step();
      left  = 1'b0;
      right = 1'b0;
      enter = 1'b0;
   endtask

   task automatic modelReset(input int keepWinner);
      for (int c = 0; c < COLS; c++) mHeight[c] = 0;
      mMoves  = 0;
      mCursor = COLS / 2;
      mPlayer = 0;
      mOver   = 0;
      mDraw   = 0;
      if (keepWinner == 0) mWinner = 0;
   endtask

   task automatic hardReset();
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      modelReset(0);
   endtask

   task automatic moveCursor(input int col);
      logic goLeft;
      goLeft = 1'($urandom_range(0, 1));
      while (mCursor != col) begin
         applyStimulus(goLeft, !goLeft, 1'b0);
         mCursor = goLeft ? (mCursor + COLS - 1) % COLS : (mCursor + 1) % COLS;
         checkOutput("cursor_step", 32'(cursor), mCursor);
      end
   endtask

   task automatic doMove(input int col, input int win, input int delay);
      moveCursor(col);
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (mHeight[col] >= ROWS) begin
         checkOutput("full_no_wr_en", 32'(wrEn), 0);
         step();
         checkOutput("full_no_chk_start", 32'(chkStart), 0);
         checkOutput("full_player", 32'(player), mPlayer);
         checkOutput("full_cursor", 32'(cursor), mCursor);
         return;
      end
      checkOutput("drop_wr_en", 32'(wrEn), 1);
      checkOutput("drop_chk_start", 32'(chkStart), 0);
      checkOutput("drop_wr_col", 32'(wrCol), col);
      checkOutput("drop_wr_row", 32'(wrRow), mHeight[col]);
      checkOutput("drop_wr_player", 32'(wrPlayer), mPlayer);
      step();
      checkOutput("start_chk_start", 32'(chkStart), 1);
      checkOutput("start_wr_en", 32'(wrEn), 0);
      checkOutput("start_wr_row_held", 32'(wrRow), mHeight[col]);
      step();
      checkOutput("wait_chk_start", 32'(chkStart), 0);
      repeat (delay) step();
      chkDone = 1'b1;
      chkWin  = 1'(win);
      step();
      mHeight[col]++;
      mMoves++;
      if (win != 0) begin
         mOver   = 1;
         mWinner = mPlayer;
      end else if (mMoves == COLS * ROWS) begin
         mOver = 1;
         mDraw = 1;
      end else begin
         mPlayer = 1 - mPlayer;
      end
      checkOutput("verdict_game_over", 32'(gameOver), mOver);
      checkOutput("verdict_player", 32'(player), mPlayer);
      checkOutput("verdict_draw", 32'(draw), mDraw);
      if (mOver != 0 && mDraw == 0) checkOutput("verdict_winner", 32'(winner), mWinner);
      if (mOver == 0 && $urandom_range(0, 1) == 1) begin
         chkWin = 1'b0;
         step();
         checkOutput("held_done_player", 32'(player), mPlayer);
         checkOutput("held_done_wr_en", 32'(wrEn), 0);
         checkOutput("held_done_chk_start", 32'(chkStart), 0);
      end
      chkDone = 1'b0;
      chkWin  = 1'b0;
   endtask

   task automatic playGame(input int lastWin);
      int c;
      for (int k = 1; k <= COLS * ROWS; k++) begin
         do c = $urandom_range(0, COLS - 1); while (mHeight[c] >= ROWS);
         doMove(c, (k == COLS * ROWS) ? lastWin : 0, $urandom_range(0, 3));
      end
   endtask

   initial begin
      int wrapExp [4] = '{2, 1, 0, 6};

      resetN = 1'b0;
      step();
      step();
      resetN = 1'b1;
      modelReset(0);
      checkOutput("reset_cursor", 32'(cursor), 3);
      checkOutput("reset_player", 32'(player), 0);
      checkOutput("reset_wr_en", 32'(wrEn), 0);
      checkOutput("reset_chk_start", 32'(chkStart), 0);
      checkOutput("reset_game_over", 32'(gameOver), 0);
      checkOutput("reset_draw", 32'(draw), 0);
      checkOutput("reset_winner", 32'(winner), 0);

      $display("[TB] cursor wrap");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("wrap_left", 32'(cursor), wrapExp[i]);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("wrap_right", 32'(cursor), 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("wrap_both", 32'(cursor), 0);
      mCursor = 0;

      $display("[TB] single drop timing");
      doMove(3, 0, 2);

      $display("[TB] full column");
      hardReset();
      for (int i = 0; i < ROWS + 1; i++) doMove(0, 0, $urandom_range(0, 3));

      $display("[TB] win by player 1");
      doMove(1, 0, 1);
      doMove(2, 1, 2);
      checkOutput("win_winner", 32'(winner), 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("over_left_ignored", 32'(cursor), mCursor);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("over_right_ignored", 32'(cursor), mCursor);
      checkOutput("over_still_over", 32'(gameOver), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      modelReset(1);
      checkOutput("restart_cursor", 32'(cursor), 3);
      checkOutput("restart_player", 32'(player), 0);
      checkOutput("restart_game_over", 32'(gameOver), 0);
      checkOutput("restart_draw", 32'(draw), 0);
      checkOutput("restart_winner_held", 32'(winner), 1);
      doMove(0, 0, 0);

      $display("[TB] draw game");
      hardReset();
      playGame(0);
      checkOutput("draw_flag", 32'(draw), 1);
      checkOutput("draw_game_over", 32'(gameOver), 1);

      $display("[TB] win on the last move");
      applyStimulus(1'b0, 1'b0, 1'b1);
      modelReset(1);
      checkOutput("restart2_draw", 32'(draw), 0);
      playGame(1);
      checkOutput("last_move_draw", 32'(draw), 0);
      checkOutput("last_move_winner", 32'(winner), 1);

      $display("[TB] reset mid-move");
      hardReset();
      moveCursor(4);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step();
      step();
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      modelReset(0);
      checkOutput("midreset_cursor", 32'(cursor), 3);
      checkOutput("midreset_player", 32'(player), 0);
      checkOutput("midreset_game_over", 32'(gameOver), 0);
      chkDone = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("midreset_no_wr_en", 32'(wrEn), 0);
         checkOutput("midreset_no_chk_start", 32'(chkStart), 0);
         checkOutput("midreset_player_hold", 32'(player), 0);
      end
      chkDone = 1'b0;
      doMove(4, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
